// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared widths, defaults and FSM encoding for the 74HC595 feeder
package shiftreg_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_GUARD = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STROBE     = 2'd1,
    ST_WAIT_BUSY  = 2'd2,
    ST_WAIT_READY = 2'd3
  } state_e;

endpackage

// File: rtl/shiftreg_feeder_if.sv
// rtl/shiftreg_feeder_if.sv - write port, driver handshake and status signals of the feeder
interface shiftreg_feeder_if #(
  parameter int DEPTH = shiftreg_pkg::DEFAULT_DEPTH
);
  import shiftreg_pkg::*;

  logic [BYTE_W-1:0]      i_wr_data;
  logic                   i_wr_en;
  logic                   i_ready;
  logic [BYTE_W-1:0]      o_data;
  logic                   o_enable;
  logic                   o_full;
  logic                   o_empty;
  logic [$clog2(DEPTH):0] o_count;
  logic                   o_overflow;
  logic                   o_busy;

  modport master (
    output i_wr_data, i_wr_en, i_ready,
    input  o_data, o_enable, o_full, o_empty, o_count, o_overflow, o_busy
  );

  modport slave (
    input  i_wr_data, i_wr_en, i_ready,
    output o_data, o_enable, o_full, o_empty, o_count, o_overflow, o_busy
  );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with count and registered overflow pulse
module byte_fifo
  import shiftreg_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [BYTE_W-1:0]      i_wr_data,
  input  logic                   i_rd_en,
  output logic [BYTE_W-1:0]      o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Fullness is judged on the current count, so a write to a full FIFO is
  // dropped even when the FSM pops in the same cycle.
  always_comb begin
    do_wr      = i_wr_en && !full;
    do_rd      = i_rd_en && !empty;
    overflow_d = i_wr_en && full;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = i_wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_rd_data  = mem_q[rd_ptr_q];
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/shiftreg_feeder.sv
// rtl/shiftreg_feeder.sv - queues bytes and strobes them one at a time into a 74HC595 driver
module shiftreg_feeder
  import shiftreg_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int GUARD = DEFAULT_GUARD
) (
  input  logic             i_clk,
  input  logic             i_rst,
  shiftreg_feeder_if.slave bus
);

  localparam int GW = $clog2(GUARD + 1);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic              pop;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, fifo_overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (bus.i_wr_en),
    .i_wr_data  (bus.i_wr_data),
    .i_rd_en    (pop),
    .o_rd_data  (fifo_rd_data),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (fifo_count),
    .o_overflow (fifo_overflow)
  );

  // The driver may never drop o_Ready; the guard counter bounds WAIT_BUSY so
  // the feeder cannot stall waiting for an edge that will not come.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    enable_d = 1'b0;
    guard_d  = guard_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && bus.i_ready) begin
          state_d  = ST_STROBE;
          pop      = 1'b1;
          data_d   = fifo_rd_data;
          enable_d = 1'b1;
        end
      end
      ST_STROBE: begin
        state_d = ST_WAIT_BUSY;
        guard_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (!bus.i_ready || guard_q == GW'(GUARD - 1)) begin
          state_d = ST_WAIT_READY;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_WAIT_READY: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      guard_q  <= guard_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_enable   = enable_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_full     = fifo_full;
  assign bus.o_empty    = fifo_empty;
  assign bus.o_count    = fifo_count;
  assign bus.o_overflow = fifo_overflow;

endmodule

// File: tb/tb_shiftreg_feeder.sv
// tb/tb_shiftreg_feeder.sv - self-checking bench for shiftreg_feeder with a behavioural 74HC595 driver
module tb_shiftreg_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic drv_auto = 1'b0;
  logic drv_fall = 1'b1;
  logic ready_man = 1'b0;
  logic ready_drv = 1'b1;

  shiftreg_feeder_if #(.DEPTH(8)) bus ();

  shiftreg_feeder #(.DEPTH(8), .GUARD(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  assign bus.i_ready = drv_auto ? ready_drv : ready_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       gap_q[$];
  int         en_times[$];
  int         n_strobes = 0;

  // Driver model: ready falls right after the strobe, the byte is shifted
  // out MSB first and reassembled, ready rises 20 cycles later.
  logic [7:0] sr, rx;
  int         sh_left = 0;
  int         hold = 0;
  logic       idle_seen = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      sh_left   = 0;
      hold      = 0;
      idle_seen = 1'b1;
      ready_drv = 1'b1;
    end else begin
      if (!bus.o_busy) idle_seen = 1'b1;
      if (bus.o_enable) begin
        n_strobes++;
        en_times.push_back(cyc);
        if (drv_auto) begin
          gap_q.push_back(idle_seen);
          idle_seen = 1'b0;
          if (drv_fall) begin
            sr        = bus.o_data;
            sh_left   = 8;
            hold      = 20;
            ready_drv = 1'b0;
          end else begin
            rx_q.push_back(bus.o_data);
          end
        end
      end else begin
        if (sh_left > 0) begin
          rx = {rx[6:0], sr[7]};
          sr = {sr[6:0], 1'b0};
          sh_left--;
          if (sh_left == 0) rx_q.push_back(rx);
        end
        if (hold > 0) begin
          hold--;
          if (hold == 0) ready_drv = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       en;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic w, input logic [7:0] wd, input logic rdy,
                         input logic [3:0] c, input logic f, input logic e, input logic o,
                         input logic en, input logic b, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.wr_en = w; v.wr_data = wd; v.ready = rdy;
    v.count = c; v.full = f; v.empty = e; v.ovf = o; v.en = en; v.busy = b; v.data = d;
    vecs.push_back(v);
  endtask

  task automatic put(input logic [7:0] b);
    bus.i_wr_data = b;
    bus.i_wr_en   = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int g = 0;
    while (rx_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((bus.o_busy || !bus.o_empty || !bus.i_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drain_check(input string tag);
    logic [7:0] got, want;
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
      check({tag, "_byte"}, 32'(got), 32'(want));
    end
    while (gap_q.size() > 0) begin
      check({tag, "_idle_gap"}, 32'(gap_q.pop_front()), 32'd1);
    end
  endtask

  initial begin
    int base;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = 8'h00;
    repeat (2) @(negedge clk);

    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      add_vec(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 4'(i), (i == 8), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    add_vec(1'b0, 1'b1, 8'h99, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 8'hEE, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
    add_vec(1'b0, 1'b1, 8'h5A, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    add_vec(1'b0, 1'b1, 8'h77, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    add_vec(1'b0, 1'b1, 8'h88, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.i_wr_en   = vecs[i].wr_en;
      bus.i_wr_data = vecs[i].wr_data;
      ready_man     = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec[%0d]", i),
            32'({bus.o_count, bus.o_full, bus.o_empty, bus.o_overflow,
                 bus.o_enable, bus.o_busy, bus.o_data}),
            32'({vecs[i].count, vecs[i].full, vecs[i].empty, vecs[i].ovf,
                 vecs[i].en, vecs[i].busy, vecs[i].data}));
    end
    bus.i_wr_en = 1'b0;

    // Three bytes through the slow driver model, in order with idle gaps.
    rst      = 1'b0;
    drv_auto = 1'b1;
    drv_fall = 1'b1;
    @(negedge clk);
    put(8'h01);
    put(8'h02);
    put(8'h03);
    wait_rx(3, 400, "seq3");
    drain_check("seq3");

    // Driver never drops ready: guard timeout then next strobe 7 cycles later.
    wait_idle();
    drv_fall = 1'b0;
    base = n_strobes;
    put(8'hAA);
    put(8'hBB);
    wait_rx(2, 200, "guard");
    drain_check("guard");
    if (en_times.size() >= base + 2) begin
      check("guard_spacing", 32'(en_times[base + 1] - en_times[base]), 32'd7);
    end else begin
      check("guard_spacing", 32'(en_times.size()), 32'(base + 2));
    end

    // Reset while waiting for ready with five bytes queued.
    wait_idle();
    drv_fall = 1'b1;
    for (int i = 0; i < 6; i++) put(8'(8'hC0 + i));
    repeat (12) @(negedge clk);
    check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    check("pre_rst_count", 32'(bus.o_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("rst_now",
          32'({bus.o_count, bus.o_busy, bus.o_enable, bus.o_empty, bus.o_full,
               bus.o_overflow, bus.o_data}),
          32'({4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    #3 rst = 1'b0;
    drain_check("pre_rst");
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    base = n_strobes;
    repeat (40) @(negedge clk);
    check("post_rst_strobes", 32'(n_strobes), 32'(base));
    check("post_rst_count", 32'(bus.o_count), 32'd0);

    // Sixteen bytes streamed with full back-pressure, through pointer wrap.
    for (int i = 0; i < 16; i++) begin
      int g = 0;
      while (bus.o_full && g < 500) begin
        @(negedge clk);
        g++;
      end
      put(8'(i * 37 + 5));
    end
    wait_rx(16, 2000, "stream");
    drain_check("stream");
    check("exp_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shiftreg_feeder.md
SHIFTREG_FEEDER -- requirements
Module: shiftreg_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in bytes, a power of two from 2 to 16.
REQ-002 The block SHALL have parameter GUARD, default 4, the maximum cycles to wait for i_ready to fall after a strobe.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port i_rst  input  1  asynchronous active-high reset.
REQ-006 Port i_wr_data  input  8  byte to enqueue.
REQ-007 Port i_wr_en  input  1  enqueue strobe, one byte per cycle high.
REQ-008 Port i_ready  input  1  downstream 74HC595 driver idle, driven by its o_Ready.
REQ-009 Port o_data  output  8  byte to the driver's i_Data.
REQ-010 Port o_enable  output  1  one-cycle start pulse to the driver's i_Enable.
REQ-011 Port o_full  output  1  FIFO holds DEPTH bytes.
REQ-012 Port o_empty  output  1  FIFO holds 0 bytes.
REQ-013 Port o_count  output  $clog2(DEPTH)+1  bytes held in the FIFO.
REQ-014 Port o_overflow  output  1  one-cycle pulse when a write is dropped.
REQ-015 Port o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, STROBE, WAIT_BUSY and WAIT_READY, with all outputs registered.
REQ-017 IDLE -> STROBE SHALL occur when the FIFO is not empty and i_ready=1, sampled at the same edge.
REQ-018 At the IDLE->STROBE edge the head byte SHALL be popped into o_data and o_enable set to 1 for exactly one cycle.
REQ-019 STROBE -> WAIT_BUSY SHALL occur unconditionally after one cycle.
REQ-020 WAIT_BUSY -> WAIT_READY SHALL occur when i_ready=0 or after GUARD cycles in WAIT_BUSY, whichever comes first.
REQ-021 WAIT_READY -> IDLE SHALL occur when i_ready=1.
REQ-022 o_data SHALL hold constant from the strobe until the FSM re-enters IDLE.
REQ-023 Latency SHALL be: write at edge k into an empty FIFO, with i_ready=1 and FSM in IDLE, gives o_enable high after edge k+1.
REQ-024 Back-to-back transfers SHALL be separated by at least one IDLE cycle.
REQ-025 A write when full SHALL be dropped with o_overflow pulsed, even if a pop occurs in the same cycle.
REQ-026 A write and a pop in the same cycle on a non-full, non-empty FIFO SHALL both take effect, leaving o_count unchanged.
REQ-027 A write to an empty FIFO SHALL NOT bypass to o_data in the same cycle.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL range 0..DEPTH.
REQ-029 i_ready=0 in IDLE SHALL hold the FSM in IDLE indefinitely, with no strobe issued.

Reset
REQ-030 Asserting i_rst SHALL immediately force: FSM IDLE, pointers 0, o_count 0, o_empty 1, o_full 0, o_enable 0, o_overflow 0, o_data 8'h00, o_busy 0.
REQ-031 Reset mid-transfer SHALL discard all queued bytes and the in-flight byte without further strobes.
REQ-032 The first strobe after reset deassertion SHALL require a fresh write.

Structure
REQ-033 Shared package shiftreg_pkg SHALL hold the FSM state encoding, byte width (8) and the default DEPTH and GUARD values.
REQ-034 FIFO storage, pointers and count SHALL live in sub-module byte_fifo; the FSM and handshake SHALL live in shiftreg_feeder.

Verification
REQ-035 Reset, then write 8'hA5 with i_ready held 1 -> o_enable high one cycle after the write, o_data=8'hA5, o_empty=1.
REQ-036 Write 3 bytes 01,02,03 with a model driver (ready falls 1 cycle after enable, rises 20 cycles later) -> three strobes in order 01,02,03, each separated by at least one IDLE cycle.
REQ-037 Hold i_ready=0 and write 9 bytes with DEPTH=8 -> o_full=1 after the 8th, o_overflow pulses on the 9th, o_count=8.
REQ-038 Driver never drops i_ready after a strobe -> WAIT_BUSY exits after GUARD=4 cycles and the next byte strobes afterwards.
REQ-039 Assert i_rst during WAIT_READY with 5 bytes queued -> o_count=0, o_busy=0, o_enable=0 immediately, and no strobe after release.
REQ-040 Integrate with the ShiftReg driver and stream 16 bytes through wrap-around -> the serial output reproduces all 16 bytes in order.
